// File: rtl/ps2_kbd_tx_if.sv
// Write-side bundle for the PS/2 keyboard transmitter: byte push, queue status and overflow flag.
// The brk input exists only when PS2_KBD_TX_BREAK_EN is defined.
interface ps2_kbd_tx_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_en;
  logic [7:0]    wr_data;
`ifdef PS2_KBD_TX_BREAK_EN
  logic          brk;
`endif
  logic          full;
  logic [LW-1:0] level;
  logic          ovf;

`ifdef PS2_KBD_TX_BREAK_EN
  modport master (output wr_en, output wr_data, output brk, input full, input level, input ovf);
  modport slave  (input wr_en, input wr_data, input brk, output full, output level, output ovf);
`else
  modport master (output wr_en, output wr_data, input full, input level, input ovf);
  modport slave  (input wr_en, input wr_data, output full, output level, output ovf);
`endif
endinterface

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: byte FIFO feeding an 11-bit frame serialiser with inter-frame gap.
// Optional macro PS2_KBD_TX_BREAK_EN adds brk, which enqueues 0xF0 ahead of wr_data atomically.
module ps2_kbd_tx #(
  parameter int CLK_DIV    = 4,
  parameter int GAP        = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  ps2_kbd_tx_if.slave  bus,
  output logic         busy,
  output logic         ps2_clk,
  output logic         ps2_data
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int TMAX = (CLK_DIV > GAP) ? CLK_DIV : GAP;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] DIV_LAST = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_GAP} state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [LW-1:0] count;
  logic [LW-1:0] add;
  logic          full;
  logic          push_one;
  logic          push_two;
  logic          drop;
  logic          start;
  logic          ovf;
  state_t        state;
  logic [TW-1:0] tmr;
  logic [3:0]    idx;
  logic [9:0]    shreg;

  assign full      = (count == LW'(FIFO_DEPTH));
  assign bus.full  = full;
  assign bus.level = count;
  assign bus.ovf   = ovf;

  // The last GAP cycle doubles as the IDLE cycle so back-to-back frames are exactly GAP apart.
  assign start = (count != {LW{1'b0}}) &&
                 ((state == S_IDLE) || ((state == S_GAP) && (tmr == GAP_LAST)));

`ifdef PS2_KBD_TX_BREAK_EN
  logic [LW-1:0] free;
  assign free = LW'(FIFO_DEPTH) - count;
`endif

  // Write acceptance, judged on occupancy before any same-cycle pop.
  always_comb begin
    push_one = 1'b0;
    push_two = 1'b0;
    drop     = 1'b0;
    add      = {LW{1'b0}};
    if (bus.wr_en) begin
`ifdef PS2_KBD_TX_BREAK_EN
      if (bus.brk) begin
        if (free >= LW'(2)) begin
          push_two = 1'b1;
          add      = LW'(2);
        end else begin
          drop = 1'b1;
        end
      end else if (full) begin
        drop = 1'b1;
      end else begin
        push_one = 1'b1;
        add      = LW'(1);
      end
`else
      if (full) begin
        drop = 1'b1;
      end else begin
        push_one = 1'b1;
        add      = LW'(1);
      end
`endif
    end else begin
      drop = 1'b0;
    end
  end

  // FIFO storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= {AW{1'b0}};
      rptr  <= {AW{1'b0}};
      count <= {LW{1'b0}};
      ovf   <= 1'b0;
    end else begin
      if (push_one) begin
        mem[wptr] <= bus.wr_data;
        wptr      <= wptr + AW'(1);
      end else if (push_two) begin
        mem[wptr]          <= 8'hF0;
        mem[wptr + AW'(1)] <= bus.wr_data;
        wptr               <= wptr + AW'(2);
      end else begin
        wptr <= wptr;
      end
      if (start) begin
        rptr <= rptr + AW'(1);
      end else begin
        rptr <= rptr;
      end
      count <= count + add - {{(LW-1){1'b0}}, start};
      if (drop) begin
        ovf <= 1'b1;
      end else begin
        ovf <= ovf;
      end
    end
  end

  // Frame serialiser: start, 8 data bits LSB first, odd parity, stop, then the idle gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tmr      <= {TW{1'b0}};
      idx      <= 4'd0;
      shreg    <= {10{1'b1}};
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      busy     <= 1'b0;
    end else if (start) begin
      state    <= S_HIGH;
      tmr      <= {TW{1'b0}};
      idx      <= 4'd0;
      shreg    <= {1'b1, odd_parity(mem[rptr]), mem[rptr]};
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b0;
      busy     <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          tmr      <= {TW{1'b0}};
          ps2_clk  <= 1'b1;
          ps2_data <= 1'b1;
          busy     <= 1'b0;
        end
        S_HIGH: begin
          if (tmr == DIV_LAST) begin
            tmr     <= {TW{1'b0}};
            ps2_clk <= 1'b0;
            state   <= S_LOW;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        S_LOW: begin
          if (tmr == DIV_LAST) begin
            tmr     <= {TW{1'b0}};
            ps2_clk <= 1'b1;
            if (idx < 4'd10) begin
              ps2_data <= shreg[0];
              shreg    <= {1'b1, shreg[9:1]};
              idx      <= idx + 4'd1;
              state    <= S_HIGH;
            end else begin
              ps2_data <= 1'b1;
              state    <= S_GAP;
            end
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        S_GAP: begin
          if (tmr == GAP_LAST) begin
            tmr   <= {TW{1'b0}};
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        default: begin
          state    <= S_IDLE;
          tmr      <= {TW{1'b0}};
          ps2_clk  <= 1'b1;
          ps2_data <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Directed bench for ps2_kbd_tx: frame bits, timing, back-to-back gap, overflow and mid-frame reset.
module tb_ps2_kbd_tx;
  localparam int CLK_DIV = 4;
  localparam int GAP = 8;
  localparam int FIFO_DEPTH = 8;

  logic clk;
  logic rst;
  logic busy;
  logic ps2_clk;
  logic ps2_data;
  int   total;
  int   bad;
  logic samples[$];
  time  fall_t[$];

  ps2_kbd_tx_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

  ps2_kbd_tx #(.CLK_DIV(CLK_DIV), .GAP(GAP), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .ps2_clk(ps2_clk), .ps2_data(ps2_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Host-side sampler: the receiver latches data on each falling PS/2 clock.
  always @(negedge ps2_clk) begin
    samples.push_back(ps2_data);
    fall_t.push_back($time);
  end

  function automatic logic [10:0] frame_at(input int b);
    logic [10:0] v;
    for (int i = 0; i < 11; i++) v[i] = (b + i < samples.size()) ? samples[b + i] : 1'bx;
    return v;
  endfunction

  function automatic longint fall_at(input int b);
    return (b < fall_t.size()) ? longint'(fall_t[b]) : 64'sd0;
  endfunction

  task automatic wait_samples(input int n, input int budget, output bit ok);
    int c = 0;
    while (samples.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    ok = (samples.size() >= n);
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while (busy !== 1'b0 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s_idle_timeout: busy=%b want 0", name, busy); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
`ifdef PS2_KBD_TX_BREAK_EN
    bus.brk = 1'b0;
`endif
    repeat (3) @(negedge clk);
    total++; if (ps2_clk !== 1'b1) begin bad++; $display("FAIL reset_ps2_clk: got %b want 1", ps2_clk); end
    total++; if (ps2_data !== 1'b1) begin bad++; $display("FAIL reset_ps2_data: got %b want 1", ps2_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
    total++; if (bus.level !== 4'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", bus.level); end
    total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", bus.full); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    int base = samples.size();
    int busy_n;
    time t1;
    logic [10:0] got;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h1C;
    @(posedge clk);
    @(negedge clk);
    bus.wr_en = 1'b0;
    total++; if (ps2_data !== 1'b1) begin bad++; $display("FAIL single_early_data: got %b want 1", ps2_data); end
    total++; if (bus.level !== 4'd1) begin bad++; $display("FAIL single_level1: got %0d want 1", bus.level); end
    @(posedge clk);
    t1 = $time;
    @(negedge clk);
    total++; if (ps2_data !== 1'b0) begin bad++; $display("FAIL single_start_data: got %b want 0", ps2_data); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
    total++; if (bus.level !== 4'd0) begin bad++; $display("FAIL single_level0: got %0d want 0", bus.level); end
    busy_n = 1;
    for (int k = 1; k < 120; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_n++;
      if (k == 90) begin
        total++;
        if ({ps2_clk, ps2_data, busy} !== 3'b111) begin
          bad++; $display("FAIL single_gap_lines: got %b want 111", {ps2_clk, ps2_data, busy});
        end
      end
    end
    total++; if (busy_n != 96) begin bad++; $display("FAIL single_busy_len: got %0d want 96", busy_n); end
    total++; if (samples.size() - base != 11) begin bad++; $display("FAIL single_nfalls: got %0d want 11", samples.size() - base); end
    got = frame_at(base);
    total++; if (got !== 11'b1_0_00011100_0) begin bad++; $display("FAIL single_bits: got %b want %b", got, 11'b1_0_00011100_0); end
    total++; if (fall_at(base) - longint'(t1) != 64'sd40) begin bad++; $display("FAIL single_first_fall: got %0d want 40", fall_at(base) - longint'(t1)); end
  endtask

  task automatic test_back_to_back;
    int base = samples.size();
    bit ok;
    logic [10:0] got;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h00;
    @(negedge clk);
    bus.wr_data = 8'hFF;
    @(negedge clk);
    bus.wr_en = 1'b0;
    wait_samples(base + 22, 400, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_timeout: got %0d falls want 22", samples.size() - base); end
    got = frame_at(base);
    total++; if (got !== 11'b1_1_00000000_0) begin bad++; $display("FAIL b2b_frame00: got %b want %b", got, 11'b1_1_00000000_0); end
    got = frame_at(base + 11);
    total++; if (got !== 11'b1_1_11111111_0) begin bad++; $display("FAIL b2b_frameFF: got %b want %b", got, 11'b1_1_11111111_0); end
    total++; if (fall_at(base + 11) - fall_at(base) != 64'sd960) begin bad++; $display("FAIL b2b_spacing: got %0d want 960", fall_at(base + 11) - fall_at(base)); end
    wait_idle("b2b");
  endtask

  task automatic test_overflow;
    int base = samples.size();
    bit ok;
    time ts;
    logic [10:0] got;
    logic [7:0] exp_q [9] = '{8'h11, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h11;
    @(posedge clk);
    @(negedge clk);
    bus.wr_en = 1'b0;
    @(posedge clk);
    ts = $time;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = exp_q[i + 1];
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL ovf_full: got %b want 1", bus.full); end
    total++; if (bus.level !== 4'd8) begin bad++; $display("FAIL ovf_level8: got %0d want 8", bus.level); end
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL ovf_pre: got %b want 0", bus.ovf); end
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hAA;
    @(negedge clk);
    bus.wr_en = 1'b0;
    total++; if (bus.ovf !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", bus.ovf); end
    total++; if (bus.level !== 4'd8) begin bad++; $display("FAIL ovf_level_hold: got %0d want 8", bus.level); end
    // Land a write on the exact edge the next frame pops while the queue is full.
    while ($time < ts + 955) @(negedge clk);
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hBB;
    @(negedge clk);
    bus.wr_en = 1'b0;
    total++; if (bus.level !== 4'd7) begin bad++; $display("FAIL fullpop_level: got %0d want 7", bus.level); end
    total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL fullpop_full: got %b want 0", bus.full); end
    total++; if (ps2_data !== 1'b0) begin bad++; $display("FAIL fullpop_start: got %b want 0", ps2_data); end
    wait_samples(base + 99, 1500, ok);
    total++; if (!ok) begin bad++; $display("FAIL ovf_drain_timeout: got %0d falls want 99", samples.size() - base); end
    for (int i = 0; i < 9; i++) begin
      got = frame_at(base + 11 * i);
      total++;
      if (got[8:1] !== exp_q[i]) begin bad++; $display("FAIL ovf_byte%0d: got %h want %h", i, got[8:1], exp_q[i]); end
    end
    wait_idle("ovf");
    total++; if (bus.ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", bus.ovf); end
    total++; if (samples.size() - base != 99) begin bad++; $display("FAIL ovf_extra_frames: got %0d falls want 99", samples.size() - base); end
  endtask

`ifdef PS2_KBD_TX_BREAK_EN
  task automatic test_break;
    int base;
    bit ok;
    logic [10:0] got;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    base = samples.size();
    bus.wr_en = 1'b1;
    bus.brk = 1'b1;
    bus.wr_data = 8'h1C;
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.brk = 1'b0;
    wait_samples(base + 22, 400, ok);
    total++; if (!ok) begin bad++; $display("FAIL brk_timeout: got %0d falls want 22", samples.size() - base); end
    got = frame_at(base);
    total++; if (got !== 11'b1_1_11110000_0) begin bad++; $display("FAIL brk_f0: got %b want %b", got, 11'b1_1_11110000_0); end
    got = frame_at(base + 11);
    total++; if (got !== 11'b1_0_00011100_0) begin bad++; $display("FAIL brk_1c: got %b want %b", got, 11'b1_0_00011100_0); end
    wait_idle("brk");
    bus.wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.wr_data = 8'h40 + 8'(i);
      @(negedge clk);
    end
    bus.brk = 1'b1;
    bus.wr_data = 8'h1C;
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.brk = 1'b0;
    total++; if (bus.level !== 4'd7) begin bad++; $display("FAIL brk_full_level: got %0d want 7", bus.level); end
    total++; if (bus.ovf !== 1'b1) begin bad++; $display("FAIL brk_full_ovf: got %b want 1", bus.ovf); end
  endtask
`endif

  task automatic test_reset_mid;
    int base = samples.size();
    int n;
    time ts;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    bus.wr_data = 8'h33;
    @(posedge clk);
    ts = $time;
    @(negedge clk);
    bus.wr_en = 1'b0;
    while ($time < ts + 415) @(negedge clk);
    total++; if (samples.size() - base != 5) begin bad++; $display("FAIL rstmid_bits_before: got %0d want 5", samples.size() - base); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (ps2_clk !== 1'b1) begin bad++; $display("FAIL rstmid_clk: got %b want 1", ps2_clk); end
    total++; if (ps2_data !== 1'b1) begin bad++; $display("FAIL rstmid_data: got %b want 1", ps2_data); end
    total++; if (bus.level !== 4'd0) begin bad++; $display("FAIL rstmid_level: got %0d want 0", bus.level); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL rstmid_ovf: got %b want 0", bus.ovf); end
    n = samples.size();
    repeat (200) @(negedge clk);
    total++; if (samples.size() != n) begin bad++; $display("FAIL rstmid_no_falls: got %0d extra want 0", samples.size() - n); end
    total++; if ({ps2_clk, ps2_data, busy} !== 3'b110) begin bad++; $display("FAIL rstmid_quiet: got %b want 110", {ps2_clk, ps2_data, busy}); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset;
    test_single;
    test_back_to_back;
    test_overflow;
`ifdef PS2_KBD_TX_BREAK_EN
    test_break;
`endif
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
